// File: rtl/acdc_pkg.sv
// Shared constants for the AC/DC input coupling stage.
// Default sample width, window size and the mode encoding.
package acdc_pkg;
  localparam int ACDC_DATA_W   = 8;
  localparam int ACDC_WIN_LOG2 = 9;

  localparam logic MODE_DC = 1'b0;
  localparam logic MODE_AC = 1'b1;
endpackage

// File: rtl/window_averager.sv
// Running mean over a power-of-two window of valid samples.
// Optional macro ACDC_SEED_EN: first sample after reset/clear preloads avg.
module window_averager
  import acdc_pkg::*;
#(
  parameter int DATA_W   = ACDC_DATA_W,
  parameter int WIN_LOG2 = ACDC_WIN_LOG2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [DATA_W-1:0] in,
  input  logic              in_valid,
  output logic [DATA_W-1:0] avg,
  output logic              avg_valid,
  output logic              avg_upd
);
  // Wide enough for a full window of max-value samples, so no overflow.
  localparam int SUM_W = DATA_W + WIN_LOG2;

  logic [SUM_W-1:0]    sum;
  logic [SUM_W-1:0]    sum_nxt;
  logic [WIN_LOG2-1:0] cnt;
  logic                win_end;

  assign sum_nxt = sum + SUM_W'(in);
  assign win_end = in_valid && (cnt == '1);

`ifdef ACDC_SEED_EN
  logic seed_pend;

  always_ff @(posedge clk) begin
    if (rst || clr)    seed_pend <= 1'b1;
    else if (in_valid) seed_pend <= 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sum       <= '0;
      cnt       <= '0;
      avg       <= '0;
      avg_valid <= 1'b0;
      avg_upd   <= 1'b0;
    end else begin
      avg_upd <= win_end;
      if (in_valid) begin
        if (win_end) begin
          avg       <= sum_nxt[SUM_W-1:WIN_LOG2];
          sum       <= '0;
          cnt       <= '0;
          avg_valid <= 1'b1;
        end else begin
          sum <= sum_nxt;
          cnt <= cnt + 1'b1;
`ifdef ACDC_SEED_EN
          if (seed_pend) avg <= in;
`endif
        end
      end
    end
  end
endmodule

// File: rtl/acdc_coupler.sv
// AC/DC coupling: registered sample minus running mean (AC) or pass-through (DC).
// Optional macro ACDC_SEED_EN seeds the mean from the first sample.
module acdc_coupler
  import acdc_pkg::*;
#(
  parameter int DATA_W   = ACDC_DATA_W,
  parameter int WIN_LOG2 = ACDC_WIN_LOG2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in,
  input  logic              in_valid,
  input  logic              mode,
  input  logic              avg_clr,
  output logic [DATA_W:0]   out,
  output logic              out_valid,
  output logic [DATA_W-1:0] avg,
  output logic              avg_valid,
  output logic              avg_upd
);
  logic [DATA_W:0] coupled;

  window_averager #(
    .DATA_W  (DATA_W),
    .WIN_LOG2(WIN_LOG2)
  ) u_avg (
    .clk      (clk),
    .rst      (rst),
    .clr      (avg_clr),
    .in       (in),
    .in_valid (in_valid),
    .avg      (avg),
    .avg_valid(avg_valid),
    .avg_upd  (avg_upd)
  );

  // One extra bit makes the difference exact: no saturation needed.
  // avg is the registered pre-edge mean, so window-end and clear samples see the old value.
  always_comb begin
    coupled = {1'b0, in};
    if (mode == MODE_AC)
      coupled = $unsigned($signed({1'b0, in}) - $signed({1'b0, avg}));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) out <= coupled;
    end
  end
endmodule

// File: tb/tb_acdc_coupler.sv
// Scoreboard bench for acdc_coupler, DATA_W=8, WIN_LOG2=2 (window of 4).
`timescale 1ns/1ps
module tb_acdc_coupler;
  localparam int DW  = 8;
  localparam int WL  = 2;
  localparam int WIN = 1 << WL;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in;
  logic          in_valid;
  logic          mode;
  logic          avg_clr;
  logic [DW:0]   out;
  logic          out_valid;
  logic [DW-1:0] avg;
  logic          avg_valid;
  logic          avg_upd;

  always #5 clk = ~clk;

  acdc_coupler #(.DATA_W(DW), .WIN_LOG2(WL)) dut (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .mode(mode),
    .avg_clr(avg_clr), .out(out), .out_valid(out_valid), .avg(avg),
    .avg_valid(avg_valid), .avg_upd(avg_upd)
  );

  int checks   = 0;
  int failures = 0;
  logic [DW:0] exp_q[$];

  // Reference model of the window mean
  int m_sum, m_cnt, m_avg;
  bit m_vld, m_pend;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW:0] model_couple(input logic md, input int v);
    int d;
    d = md ? v - m_avg : v;
    return d[DW:0];
  endfunction

  task automatic model_reset();
    m_sum = 0; m_cnt = 0; m_avg = 0; m_vld = 0; m_pend = 1;
  endtask

  // Drive one cycle; returns #1 after the edge so callers may inspect outputs.
  task automatic send(input int v, input logic md, input bit vld, input bit clr);
    bit exp_upd;
    exp_upd  = 0;
    in       = v[DW-1:0];
    mode     = md;
    in_valid = vld;
    avg_clr  = clr;
    if (vld) exp_q.push_back(model_couple(md, v));
    if (clr) model_reset();
    else if (vld) begin
      if (m_cnt == WIN - 1) begin
        m_avg = (m_sum + v) / WIN;
        m_sum = 0; m_cnt = 0; m_vld = 1; exp_upd = 1;
      end else begin
`ifdef ACDC_SEED_EN
        if (m_pend) m_avg = v;
`endif
        m_sum += v;
        m_cnt++;
      end
      m_pend = 0;
    end
    @(posedge clk); #1;
    in_valid = 0;
    avg_clr  = 0;
    chk("out_valid", out_valid, vld);
    chk("avg", avg, m_avg);
    chk("avg_valid", avg_valid, m_vld);
    chk("avg_upd", avg_upd, exp_upd);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      chk("gap_out_valid", out_valid, 0);
      chk("gap_avg_upd", avg_upd, 0);
    end
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; avg_clr = 0;
    @(posedge clk); #1;
    rst = 0;
    chk("rst_out", out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_avg", avg, 0);
    chk("rst_avg_valid", avg_valid, 0);
    chk("rst_avg_upd", avg_upd, 0);
    exp_q.delete();
    model_reset();
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) chk("spurious_out_valid", 1, 0);
      else chk("out", out, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int w1[4] = '{10, 20, 30, 40};
    int w2[4] = '{255, 255, 255, 254};
    int gaps[4] = '{0, 5, 3, 1};
    rst = 1; in = 0; in_valid = 0; mode = 0; avg_clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // DC pass-through
    send(200, 1'b0, 1, 0);
    chk("dc_out", out, 9'h0C8);
    send(0, 1'b0, 0, 1);

    // Window mean
    for (int i = 0; i < 4; i++) send(w1[i], 1'b1, 1, 0);
    chk("win_avg", avg, 25);
    chk("win_upd", avg_upd, 1);
    chk("win_avg_valid", avg_valid, 1);
`ifndef ACDC_SEED_EN
    chk("win_last_out", out, 9'h028);
`endif
    send(25, 1'b1, 1, 0);
    chk("ac_zero", out, 9'h000);
    send(0, 1'b1, 1, 0);
    chk("ac_neg25", out, 9'h1E7);

    // Truncation and extremes
    send(0, 1'b0, 0, 1);
    for (int i = 0; i < 4; i++) send(w2[i], 1'b1, 1, 0);
    chk("trunc_avg", avg, 254);
    send(0, 1'b1, 1, 0);
    chk("ac_neg254", out, 9'h102);
    send(255, 1'b1, 1, 0);
    chk("ac_pos1", out, 9'h001);
    send(0, 1'b0, 0, 1);
    send(255, 1'b1, 1, 0);
    chk("ac_pos255", out, 9'h0FF);

    // Gapped input
    send(0, 1'b0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      send(w1[i], 1'b1, 1, 0);
      idle(gaps[i]);
    end
    chk("gap_avg", avg, 25);

    // Clear mid-window, coupled against the old mean
    send(10, 1'b1, 1, 0);
    send(20, 1'b1, 1, 0);
    send(50, 1'b1, 1, 1);
    chk("clr_out", out, 9'h019);
    chk("clr_avg", avg, 0);
    chk("clr_avg_valid", avg_valid, 0);
    send(40, 1'b1, 1, 0);
    send(40, 1'b0, 1, 0);
    send(40, 1'b1, 1, 0);
    send(44, 1'b0, 1, 0);
    chk("post_clr_avg", avg, 41);

    // Reset mid-window discards the partial sum
    for (int i = 0; i < 3; i++) send(200, 1'b1, 1, 0);
    do_reset();
    for (int i = 0; i < 4; i++) send(8, 1'b0, 1, 0);
    chk("post_rst_avg", avg, 8);

    // Seeding behaviour
    do_reset();
    send(100, 1'b1, 1, 0);
    chk("seed_first_out", out, 9'h064);
    chk("seed_avg_valid", avg_valid, 0);
`ifdef ACDC_SEED_EN
    chk("seed_avg", avg, 100);
    send(100, 1'b1, 1, 0);
    chk("seed_second_out", out, 9'h000);
`else
    chk("noseed_avg", avg, 0);
    send(100, 1'b1, 1, 0);
    chk("noseed_second_out", out, 9'h064);
`endif

    // Random traffic against the model
    for (int i = 0; i < 80; i++) begin
      send($urandom_range(0, 255), 1'($urandom_range(0, 1)),
           $urandom_range(0, 7) != 0, $urandom_range(0, 11) == 0);
      idle($urandom_range(0, 2));
    end

    idle(2);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/acdc_coupler.md
Name: acdc_coupler

Overview:
Parametrised, sequential successor to the oscilloscope's AC/DC input coupling stage. It sits between the ADC sample capture and the trigger/display path. It tracks the signal mean over a power-of-two window of valid samples, entirely in hardware. In AC mode it outputs each sample minus the current mean; in DC mode it passes the sample through. Output is registered and carries a valid strobe.

Parameters:
- DATA_W, 8, unsigned ADC sample width.
- WIN_LOG2, 9, log2 of the averaging window in samples (window = 2**WIN_LOG2, default 512). Legal range 1..16.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in  in  DATA_W  unsigned ADC sample.
- in_valid  in  1  sample strobe, one sample per asserted cycle.
- mode  in  1  1 = AC (subtract mean), 0 = DC (pass-through); sampled with in_valid.
- avg_clr  in  1  synchronous clear of the accumulator, window counter and mean.
- out  out  DATA_W+1  signed coupled sample.
- out_valid  out  1  out holds a new sample.
- avg  out  DATA_W  current mean.
- avg_valid  out  1  at least one full window has completed since reset or clear.
- avg_upd  out  1  one-cycle pulse when avg is refreshed.

Behaviour:
- Reset (rst=1 at an edge): out=0, out_valid=0, avg=0, avg_valid=0, avg_upd=0, sum=0, cnt=0. Reset mid-window discards the partial sum.
- Priority at each edge: rst > avg_clr > normal operation.
- Internal state: sum is DATA_W+WIN_LOG2 bits unsigned and cannot overflow. cnt is WIN_LOG2 bits.
- Accumulation on in_valid=1:
  - If cnt < 2**WIN_LOG2-1: sum <= sum+in; cnt <= cnt+1.
  - If cnt == 2**WIN_LOG2-1 (window end): avg <= (sum+in) >> WIN_LOG2, truncating. Then sum <= 0, cnt <= 0, avg_valid <= 1, avg_upd <= 1 for exactly one cycle.
- No in_valid: sum, cnt and avg hold; gaps of any length are allowed.
- Coupling, latency 1 cycle: on an in_valid edge, out_valid <= 1 and out <= mode ? ($signed({1'b0,in}) - $signed({1'b0,avg})) : {1'b0,in}.
  - The subtraction uses avg as it was before that edge. A window-end sample is coupled against the old mean.
  - Otherwise out_valid <= 0 and out holds its last value.
- Range of out: AC spans -(2**DATA_W-1)..+(2**DATA_W-1), so it never saturates. DC spans 0..2**DATA_W-1.
- Accumulation runs regardless of mode. A mode toggle affects only the next sample's coupling and never restarts the window.
- avg_clr=1:
  - sum=0, cnt=0, avg=0, avg_valid=0, avg_upd=0.
  - If in_valid is also 1 in that cycle, the sample is still coupled (out_valid=1) against the pre-clear avg but is not accumulated.

Optional Feature:
ACDC_SEED_EN.
- Defined: the first valid sample after reset or avg_clr also loads avg <= in, with avg_valid staying 0. AC output therefore starts near zero instead of equal to the raw sample during the first window. That seeding sample is accumulated normally and does not pulse avg_upd.
- Undefined: avg stays 0 until the first window completes.

Decomposition:
- Package acdc_pkg holds:
  - default constants ACDC_DATA_W=8 and ACDC_WIN_LOG2=9;
  - the mode encoding localparams MODE_DC=1'b0 and MODE_AC=1'b1.
- One sub-module, window_averager, owns sum, cnt, avg, avg_valid and avg_upd, plus the seed logic. The top level keeps only the coupling subtractor and the output registers.

Test Plan (DATA_W=8, WIN_LOG2=2, window 4):
- DC pass-through: mode=0, in=200, in_valid=1 -> next cycle out_valid=1, out=+200 (9'h0C8); avg stays 0.
- Window mean: mode=1, samples 10,20,30,40 -> avg_upd pulses once after the 4th sample, avg=25, avg_valid=1. The 4th sample gives out=+40 (old avg 0). The next sample 25 gives out=0; the following sample 0 gives out=-25 (9'h1E7).
- Truncation and extremes: samples 255,255,255,254 -> avg=254. Then in=0 AC -> out=-254; in=255 -> out=+1. With avg=0, in=255 -> out=+255.
- Gapped input: the same 4 samples separated by 0-5 idle cycles -> identical avg=25. out_valid is high only on the cycle after each sample, and cnt is unchanged during gaps.
- Clear and reset mid-window:
  - after 2 samples, avg_clr together with in=50 -> out=50-(old avg); avg=0, avg_valid=0.
  - the next 4 samples alone form the new window.
  - rst after 3 samples -> all outputs 0, and the next full window averages only post-reset samples.
- ACDC_SEED_EN: after rst, first sample 100 in AC mode -> out=+100 and avg=100 with avg_valid=0. Second sample 100 -> out=0. Without the macro the second sample gives out=+100.
